// File: rtl/freq_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_counter_pkg
// Description : Shared types and constants for the frequency-counter gate
//               controller (state encoding, default widths, display limit).
// Revision    : 1.0 - initial release
// ============================================================================
package freq_counter_pkg;

    localparam int PERIOD_W = 12;
    localparam int EDGE_W   = 7;
    // Two-digit display: anything above this is shown as the maximum.
    localparam int SAT_MAX  = 99;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

endpackage : freq_counter_pkg
`default_nettype wire

// File: rtl/freq_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : freq_gate_ctrl
// Description : Gate-window controller for an external edge counter. Clears
//               the counter, opens a gate of period_reg clock cycles, then
//               latches a saturated edge count for display.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_gate_ctrl #(
    parameter int                    PERIOD_W       = freq_counter_pkg::PERIOD_W,
    parameter int                    EDGE_W         = freq_counter_pkg::EDGE_W,
    parameter logic [PERIOD_W-1:0]   DEFAULT_PERIOD = PERIOD_W'(1000)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                load_period,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic [EDGE_W-1:0]   edge_count,
    output logic                cnt_clr,
    output logic                cnt_en,
    output logic [EDGE_W-1:0]   result,
    output logic                result_valid,
    output logic [1:0]          dbg_state,
    output logic [2:0]          dbg_clk_count
);

    import freq_counter_pkg::*;

    localparam logic [EDGE_W-1:0]   c_sat_value = EDGE_W'(SAT_MAX);
    localparam logic [PERIOD_W-1:0] c_one       = PERIOD_W'(1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [PERIOD_W-1:0] r_clk_count;
    logic [PERIOD_W-1:0] w_clk_count_nxt;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] w_eff_period;
    logic                w_count_done;
    logic                w_abort;
    logic                w_latch_fire;
    logic [EDGE_W-1:0]   r_result;
    logic [EDGE_W-1:0]   w_result_sat;
    logic                r_result_valid;

    // A zero period would otherwise never match; treat it as a 1-cycle gate.
    assign w_eff_period = (r_period == '0) ? c_one : r_period;
    assign w_count_done = (r_clk_count == (w_eff_period - c_one));

    // Loading a period or dropping the enable both abandon the measurement.
    assign w_abort      = load_period || !ena;
    assign w_latch_fire = !w_abort && (r_state == ST_LATCH);

    assign w_result_sat = (32'(edge_count) > 32'(SAT_MAX)) ? c_sat_value : edge_count;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (!w_abort) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_COUNT;
                ST_COUNT: w_state_nxt = w_count_done ? ST_LATCH : ST_COUNT;
                ST_LATCH: w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: Moore output decode
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (r_state)
            ST_IDLE:  cnt_clr = 1'b1;
            ST_COUNT: cnt_en  = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Gate-length counter: runs only inside COUNT, zero everywhere else
    // ------------------------------------------------------------------------
    always_comb begin
        w_clk_count_nxt = '0;
        if (!w_abort && (r_state == ST_COUNT) && !w_count_done) begin
            w_clk_count_nxt = r_clk_count + c_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_count <= '0;
        end else begin
            r_clk_count <= w_clk_count_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Period register: loads even while disabled
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= DEFAULT_PERIOD;
        end else if (load_period) begin
            r_period <= period_in;
        end
    end

    // ------------------------------------------------------------------------
    // Result register and one-cycle update strobe
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_latch_fire;
            if (w_latch_fire) begin
                r_result <= w_result_sat;
            end
        end
    end

    assign result        = r_result;
    assign result_valid  = r_result_valid;
    assign dbg_state     = r_state;
    assign dbg_clk_count = r_clk_count[2:0];

endmodule : freq_gate_ctrl
`default_nettype wire

// File: tb/tb_freq_gate_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_freq_gate_ctrl
// Description : Self-checking bench for freq_gate_ctrl: measurement-position
//               model checked every cycle plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_gate_ctrl;

    localparam int PERIOD_W = 12;
    localparam int EDGE_W   = 7;

    logic                clk         = 1'b0;
    logic                rst_n       = 1'b0;
    logic                ena         = 1'b0;
    logic                load_period = 1'b0;
    logic [PERIOD_W-1:0] period_in   = '0;
    logic [EDGE_W-1:0]   edge_count  = '0;
    logic                cnt_clr;
    logic                cnt_en;
    logic [EDGE_W-1:0]   result;
    logic                result_valid;
    logic [1:0]          dbg_state;
    logic [2:0]          dbg_clk_count;

    int n_checks = 0;
    int n_errors = 0;

    freq_gate_ctrl #(
        .PERIOD_W       (PERIOD_W),
        .EDGE_W         (EDGE_W),
        .DEFAULT_PERIOD (12'd1000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .load_period   (load_period),
        .period_in     (period_in),
        .edge_count    (edge_count),
        .cnt_clr       (cnt_clr),
        .cnt_en        (cnt_en),
        .result        (result),
        .result_valid  (result_valid),
        .dbg_state     (dbg_state),
        .dbg_clk_count (dbg_clk_count)
    );

    always #5 clk = ~clk;

    // Model: position within a measurement. 0 = clear cycle, 1..eff = gate
    // open, eff+1 = latch cycle.
    int m_pos    = 0;
    int m_period = 1000;
    int m_result = 0;
    bit m_valid  = 1'b0;

    function automatic int eff_of(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos    = 0;
            m_period = 1000;
            m_result = 0;
            m_valid  = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (load_period) begin
                m_period = int'(period_in);
                m_pos    = 0;
            end else if (!ena) begin
                m_pos = 0;
            end else if (m_pos == eff_of(m_period) + 1) begin
                m_result = (int'(edge_count) > 99) ? 99 : int'(edge_count);
                m_valid  = 1'b1;
                m_pos    = 0;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        int  eff;
        bit  in_gate;
        logic [1:0] e_state;
        logic [2:0] e_cc;
        logic [14:0] exp_v;
        logic [14:0] act_v;
        eff     = eff_of(m_period);
        in_gate = (m_pos >= 1) && (m_pos <= eff);
        e_state = (m_pos == 0) ? 2'd0 : (in_gate ? 2'd1 : 2'd2);
        e_cc    = in_gate ? 3'((m_pos - 1) % 8) : 3'd0;
        exp_v   = {e_state, (m_pos == 0), in_gate, e_cc, m_valid, 7'(m_result)};
        act_v   = {dbg_state, cnt_clr, cnt_en, dbg_clk_count, result_valid, result};
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL model_cycle t=%0t got state=%0d clr=%0b en=%0b cc=%0d valid=%0b result=%0d required state=%0d clr=%0b en=%0b cc=%0d valid=%0b result=%0d",
                     $time, dbg_state, cnt_clr, cnt_en, dbg_clk_count, result_valid, result,
                     e_state, (m_pos == 0), in_gate, e_cc, m_valid, m_result);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Count rising edges until result_valid is seen; -1 if the bound expires.
    task automatic edges_to_valid(input int max, output int n, output int en_cycles);
        n = 0;
        en_cycles = 0;
        while (n < max) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (cnt_en) en_cycles++;
            if (result_valid) return;
        end
        n = -1;
    endtask

    task automatic load(input int p);
        #1;
        period_in   = PERIOD_W'(p);
        load_period = 1'b1;
        @(negedge clk);
        #1;
        load_period = 1'b0;
    endtask

    int n;
    int en;
    int sat_in  [6] = '{120, 100, 99, 98, 0, 127};
    int sat_exp [6] = '{ 99,  99, 99, 98, 0,  99};

    initial begin
        // Reset held three cycles
        ena = 1'b1;
        edge_count = 7'd50;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", dbg_state, 0);
        chk("reset_cnt_clr", cnt_clr, 1);
        chk("reset_cnt_en", cnt_en, 0);
        chk("reset_result", result, 0);
        chk("reset_valid", result_valid, 0);
        #1 rst_n = 1'b1;
        edges_to_valid(1100, n, en);
        chk("default_period_first_valid", n, 1002);
        chk("default_period_gate_len", en, 1000);
        chk("default_period_result", result, 50);

        // Period 5, edge count 37
        edge_count = 7'd37;
        load(5);
        edges_to_valid(50, n, en);
        chk("p5_first_valid", n, 7);
        edges_to_valid(50, n, en);
        chk("p5_valid_interval", n, 7);
        chk("p5_gate_len", en, 5);
        chk("p5_result", result, 37);

        // Saturation at period 3
        load(3);
        for (int i = 0; i < 6; i++) begin
            edge_count = 7'(sat_in[i]);
            edges_to_valid(50, n, en);
            chk($sformatf("sat_interval_%0d", sat_in[i]), n, 5);
            chk($sformatf("sat_result_%0d", sat_in[i]), result, sat_exp[i]);
        end

        // Zero period behaves as one
        edge_count = 7'd37;
        load(0);
        edges_to_valid(50, n, en);
        chk("p0_first_valid", n, 3);
        edges_to_valid(50, n, en);
        chk("p0_valid_interval", n, 3);
        chk("p0_gate_len", en, 1);

        // Load during COUNT cycle 2 of 5
        load(5);
        edges_to_valid(50, n, en);
        chk("p5b_result", result, 37);
        edge_count = 7'd11;
        @(negedge clk);
        @(negedge clk);
        chk("mid_count_state", dbg_state, 1);
        chk("mid_count_cc", dbg_clk_count, 1);
        load(4);
        chk("load_mid_state", dbg_state, 0);
        chk("load_mid_valid", result_valid, 0);
        chk("load_mid_result", result, 37);
        edges_to_valid(50, n, en);
        chk("p4_first_valid", n, 6);
        chk("p4_gate_len", en, 4);
        chk("p4_result", result, 11);

        // Load while in LATCH
        n = 0;
        while (dbg_state != 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_latch", dbg_state, 2);
        edge_count = 7'd22;
        load(2);
        chk("load_latch_state", dbg_state, 0);
        chk("load_latch_valid", result_valid, 0);
        chk("load_latch_result", result, 11);
        edges_to_valid(50, n, en);
        chk("p2_first_valid", n, 4);
        chk("p2_gate_len", en, 2);
        chk("p2_result", result, 22);

        // Enable low for 4 cycles mid-COUNT
        load(5);
        edge_count = 7'd60;
        repeat (3) @(negedge clk);
        chk("pre_disable_state", dbg_state, 1);
        #1 ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("disabled_state_%0d", i), dbg_state, 0);
            chk($sformatf("disabled_cnt_en_%0d", i), cnt_en, 0);
            chk($sformatf("disabled_valid_%0d", i), result_valid, 0);
        end
        #1 ena = 1'b1;
        edges_to_valid(50, n, en);
        chk("reenable_first_valid", n, 7);
        chk("reenable_gate_len", en, 5);
        chk("reenable_result", result, 60);

        // Load while disabled: period taken, FSM held
        #1 ena = 1'b0;
        load(3);
        @(negedge clk);
        chk("load_disabled_state", dbg_state, 0);
        #1 ena = 1'b1;
        edges_to_valid(50, n, en);
        chk("load_disabled_first_valid", n, 5);
        chk("load_disabled_gate_len", en, 3);

        // Asynchronous reset mid-COUNT, period returns to default
        load(6);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_state", dbg_state, 0);
        chk("async_rst_cnt_clr", cnt_clr, 1);
        chk("async_rst_cnt_en", cnt_en, 0);
        chk("async_rst_result", result, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        edges_to_valid(1100, n, en);
        chk("rst_again_first_valid", n, 1002);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_freq_gate_ctrl
`default_nettype wire

// File: doc/freq_gate_ctrl.md
FREQ_GATE_CTRL -- requirements
Module: freq_gate_ctrl

Interface
REQ-001 Parameter PERIOD_W, default 12, width of gate-period register and clock-cycle counter.
REQ-002 Parameter EDGE_W, default 7, width of edge_count input and result output.
REQ-003 Parameter DEFAULT_PERIOD, default 12'd1000, gate period loaded at reset.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 ena  in  1  design enable; low forces quiescent IDLE.
REQ-007 load_period  in  1  level; high loads period_in and restarts the measurement.
REQ-008 period_in  in  PERIOD_W  new gate period, in clk cycles.
REQ-009 edge_count  in  EDGE_W  running count from the external edge counter.
REQ-010 cnt_clr  out  1  clear strobe to the edge counter.
REQ-011 cnt_en  out  1  count enable to the edge counter (gate window).
REQ-012 result  out  EDGE_W  latched, saturated edge count for the display.
REQ-013 result_valid  out  1  one-cycle pulse, result updated.
REQ-014 dbg_state  out  2  current FSM state encoding.
REQ-015 dbg_clk_count  out  3  clock-cycle counter bits [2:0].

Function
REQ-016 The FSM states SHALL be IDLE=2'd0, COUNT=2'd1, LATCH=2'd2; 2'd3 is illegal and SHALL transition to IDLE.
REQ-017 cnt_clr SHALL be 1 exactly when state==IDLE; cnt_en SHALL be 1 exactly when state==COUNT; both are Moore decodes.
REQ-018 IDLE SHALL clear clk_count to 0 and go to COUNT on the next edge when ena=1 and load_period=0.
REQ-019 COUNT SHALL increment clk_count each cycle and go to LATCH on the edge where clk_count==eff_period-1.
REQ-020 eff_period SHALL equal period_reg, except period_reg==0, which SHALL be treated as 1.
REQ-021 LATCH SHALL go to IDLE unconditionally; on that edge result <= min(edge_count, 99) and result_valid <= 1.
REQ-022 result_valid SHALL be high for exactly one cycle, the first IDLE cycle after LATCH, and 0 otherwise.
REQ-023 One measurement SHALL take eff_period+2 cycles: 1 IDLE, eff_period COUNT, 1 LATCH.
REQ-024 load_period=1 on any edge SHALL set period_reg <= period_in, state <= IDLE and clk_count <= 0.
REQ-025 On that edge result_valid SHALL be 0 and result SHALL hold.
REQ-026 load_period held high SHALL keep the FSM in IDLE; counting resumes on the first edge after it falls.
REQ-027 load_period SHALL take priority over LATCH on the same edge: result is not updated.
REQ-028 ena=0 SHALL force state <= IDLE and clk_count <= 0 with no result update.
REQ-029 Under ena=0, period_reg SHALL still load; load_period and ena=0 together SHALL act as load then hold.
REQ-030 clk_count SHALL never wrap: COUNT exits at eff_period-1 ≤ 2^PERIOD_W-2.
REQ-031 Saturation SHALL compare the full EDGE_W value against 99; values 100..127 yield 99.

Reset
REQ-032 While rst_n=0: state=IDLE, clk_count=0, period_reg=DEFAULT_PERIOD, result=0, result_valid=0.
REQ-033 While rst_n=0, cnt_clr=1 and cnt_en=0.
REQ-034 Reset assertion SHALL take effect without a clock edge.
REQ-035 The first COUNT cycle after release SHALL follow one IDLE cycle.

Structure
REQ-036 Shared package freq_counter_pkg SHALL hold the state enum, PERIOD_W, EDGE_W and SAT_MAX=99.
REQ-037 The block SHALL be a single module with no sub-modules: FSM, clk_count, period_reg, and result register with saturator.

Verification
REQ-038 Reset: rst_n low 3 cycles, release -> dbg_state=0, cnt_clr=1, result=0, valid=0; first valid pulse at 1002 cycles after release with DEFAULT_PERIOD=1000.
REQ-039 Load period=5, edge_count held at 37 -> cnt_en high exactly 5 cycles, result=37, valid pulse every 7 cycles.
REQ-040 period=3, edge_count=120 at LATCH -> result=99.
REQ-041 period=0 -> cnt_en high 1 cycle per 3-cycle measurement.
REQ-042 load_period pulsed at COUNT cycle 2 of 5, and separately in LATCH -> next state IDLE, no valid pulse, result unchanged, new period used.
REQ-043 ena low for 4 cycles mid-COUNT -> dbg_state=0, cnt_en=0, no valid pulse; full measurement restarts after ena returns high.
